// File: rtl/npn_pkg.sv
// Shared constants, the per-channel transform type and permutation helpers
// for the NPN-programmable LUT pipeline.
package npn_pkg;

    // Upper bounds on K so helpers can work on one fixed-width vector.
    localparam int MAX_K      = 6;
    localparam int MAX_PW     = 3;
    localparam int MAX_PERM_W = MAX_K * MAX_PW;

    // Reset function (NPN class 0x177E) and the K=4 identity permutation.
    localparam logic [15:0] TT_177E    = 16'h177E;
    localparam logic [7:0]  PERM_ID_K4 = 8'hE4;

    // One NPN transform applied to every channel: input permutation,
    // input negation and output negation, sized for the largest K.
    typedef struct packed {
        logic [MAX_PERM_W-1:0] perm;
        logic [MAX_K-1:0]      neg_in;
        logic                  neg_out;
    } npn_xform_t;

    // Field width of one permutation entry for a given K.
    function automatic int perm_field_w(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

    // True when the k fields of perm name every index 0..k-1 exactly once.
    // A field >= k makes the permutation invalid.
    function automatic logic perm_is_bijective(input int k,
                                               input logic [MAX_PERM_W-1:0] perm);
        logic [MAX_K-1:0] seen;
        logic             ok;
        int               pw;
        int               idx;
        seen = '0;
        ok   = 1'b1;
        pw   = perm_field_w(k);
        idx  = 0;
        for (int j = 0; j < MAX_K; j++) begin
            if (j < k) begin
                idx = int'(perm >> (j * pw)) & ((1 << pw) - 1);
                if (idx >= k) begin
                    ok = 1'b0;
                end else if (seen[idx]) begin
                    ok = 1'b0;
                end else begin
                    seen[idx] = 1'b1;
                end
            end
        end
        return ok;
    endfunction

    // Identity permutation (field j = j) for a given K.
    function automatic logic [MAX_PERM_W-1:0] perm_identity(input int k);
        logic [MAX_PERM_W-1:0] p;
        int                    pw;
        p  = '0;
        pw = perm_field_w(k);
        for (int j = 0; j < MAX_K; j++) begin
            if (j < k) begin
                p = p | (MAX_PERM_W'(j) << (j * pw));
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/npn_lut_eval.sv
// Combinational truth-table lookup for one channel: y = tt[u] ^ neg_out.
module npn_lut_eval
    import npn_pkg::*;
#(
    parameter int K = 4
) (
    input  logic [(1<<K)-1:0] tt,
    input  logic [K-1:0]      u,
    input  logic              neg_out,
    output logic              y
);

    // u is already permuted and input-negated, so it indexes the table directly.
    assign y = tt[u] ^ neg_out;

endmodule

// File: rtl/npn_lut_pipe.sv
// Two-stage, N_CH-wide programmable K-input Boolean evaluator.
// S1 holds the permuted/negated inputs, S2 holds the looked-up results.
//
// Handshake: a transfer happens on a side in any cycle where its valid and
// ready are both high at the rising edge. The producer keeps valid and data
// stable until accepted; out_valid/out_y never change while out_valid is
// high and out_ready is low.
module npn_lut_pipe
    import npn_pkg::*;
#(
    parameter  int                 K        = 4,
    parameter  int                 N_CH     = 4,
    parameter  logic [(1<<K)-1:0]  TT_RESET = TT_177E,
    localparam int                 PW       = $clog2(K),
    localparam int                 TTW      = 1 << K
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_CH*K-1:0]    in_x,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_CH-1:0]      out_y,
    input  logic                 cfg_we,
    input  logic [TTW-1:0]       cfg_tt,
    input  logic [K*PW-1:0]      cfg_perm,
    input  logic [K-1:0]         cfg_neg_in,
    input  logic                 cfg_neg_out,
    output logic                 cfg_ready,
    output logic                 cfg_err
);

    localparam logic [MAX_PERM_W-1:0] PERM_ID_FULL = perm_identity(K);
    localparam logic [K*PW-1:0]       PERM_RST     = PERM_ID_FULL[K*PW-1:0];

    // Pipeline state
    logic                s1_v_q, s1_v_d;
    logic [N_CH*K-1:0]   s1_u_q, s1_u_d;
    logic                s2_v_q, s2_v_d;
    logic [N_CH-1:0]     s2_y_q, s2_y_d;

    // Configuration state
    logic [TTW-1:0]      tt_q, tt_d;
    logic [K*PW-1:0]     perm_q, perm_d;
    logic [K-1:0]        neg_in_q, neg_in_d;
    logic                neg_out_q, neg_out_d;
    logic                cfg_err_q, cfg_err_d;

    // Control and datapath nets
    logic                adv1, adv2;
    logic                in_accept;
    logic                perm_ok;
    logic                cfg_accept;
    logic [N_CH*K-1:0]   u_new;
    logic [N_CH-1:0]     y_eval;

    // Stage advance and input ready; config writes block input for that cycle.
    always_comb begin
        adv2      = ~s2_v_q | out_ready;
        adv1      = ~s1_v_q | adv2;
        in_ready  = adv1 & ~cfg_we;
        in_accept = in_valid & in_ready;
    end

    // Apply the shared permutation and input negation to every channel.
    always_comb begin
        logic [K-1:0]  x_ch;
        logic [PW-1:0] src;
        u_new = '0;
        x_ch  = '0;
        src   = '0;
        for (int c = 0; c < N_CH; c++) begin
            x_ch = in_x[c*K +: K];
            for (int j = 0; j < K; j++) begin
                src             = perm_q[j*PW +: PW];
                u_new[c*K + j]  = x_ch[src] ^ neg_in_q[j];
            end
        end
    end

    // One table lookup per channel on the S1 contents.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        npn_lut_eval #(
            .K (K)
        ) u_eval (
            .tt      (tt_q),
            .u       (s1_u_q[c*K +: K]),
            .neg_out (neg_out_q),
            .y       (y_eval[c])
        );
    end

    // Stage next-state: data registers only load when a stage takes new data.
    always_comb begin
        s1_v_d = s1_v_q;
        s1_u_d = s1_u_q;
        s2_v_d = s2_v_q;
        s2_y_d = s2_y_q;
        if (adv1) begin
            s1_v_d = in_accept;
            if (in_accept) begin
                s1_u_d = u_new;
            end
        end
        if (adv2) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_y_d = y_eval;
            end
        end
    end

    // Config writes land only on an empty pipeline with a valid permutation.
    always_comb begin
        cfg_ready  = ~s1_v_q & ~s2_v_q;
        perm_ok    = perm_is_bijective(K, MAX_PERM_W'(cfg_perm));
        cfg_accept = cfg_we & cfg_ready & perm_ok;
        tt_d       = tt_q;
        perm_d     = perm_q;
        neg_in_d   = neg_in_q;
        neg_out_d  = neg_out_q;
        cfg_err_d  = cfg_err_q;
        if (cfg_accept) begin
            tt_d      = cfg_tt;
            perm_d    = cfg_perm;
            neg_in_d  = cfg_neg_in;
            neg_out_d = cfg_neg_out;
            cfg_err_d = 1'b0;
        end else if (cfg_we) begin
            cfg_err_d = 1'b1;
        end
    end

    // All state registers; reset drops in-flight data and restores config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_u_q    <= '0;
            s2_v_q    <= 1'b0;
            s2_y_q    <= '0;
            tt_q      <= TT_RESET;
            perm_q    <= PERM_RST;
            neg_in_q  <= '0;
            neg_out_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_u_q    <= s1_u_d;
            s2_v_q    <= s2_v_d;
            s2_y_q    <= s2_y_d;
            tt_q      <= tt_d;
            perm_q    <= perm_d;
            neg_in_q  <= neg_in_d;
            neg_out_q <= neg_out_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_y     = s2_y_q;
    assign cfg_err   = cfg_err_q;

endmodule
